credit_packet_allocator: RTL
============================

Name: credit_packet_allocator

Overview:
- Output-port allocator for the 5-port mesh router (N, E, W, S, L inputs).
- Shares one output link among the five input ports and holds the grant for a whole packet (head to tail flit).
- Gates each flit on credit-based flow control from the downstream input buffer.
- Drives the crossbar select for that output; one instance per router output port.

Parameters:
CREDITS, 4, downstream buffer depth in flits; reset credit count; must be 1..15
CW, 4, credit counter width; must satisfy 2^CW > CREDITS

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Req  in  5  per-input request for this output; bit0=N, bit1=E, bit2=W, bit3=S, bit4=L; stays high while that input has a flit pending
Tail  in  5  per-input tail-flit flag; same bit order; qualified by Req
Credit_in  in  1  one-cycle pulse: downstream freed one buffer slot
Grant  out  5  one-hot or zero; combinational; flit from input i crosses this cycle when Grant[i]=1
Xbar_sel  out  5  registered one-hot owner select; N=00001, E=00010, W=00100, S=01000, L=10000; 00000 when idle
Valid_out  out  1  OR of Grant; downstream write strobe
Credit_cnt  out  CW  current credit count
Busy  out  1  1 while locked to an owner
Err  out  1  sticky credit-overflow flag

Behaviour:
- Reset and mid-operation reset:
  - Synchronous, active-high: state=IDLE, owner=0, rr_ptr=4 (L highest), Credit_cnt=CREDITS, Xbar_sel=00000, Busy=0, Err=0.
  - Grant and Valid_out are 0 while rst is high.
  - Reset mid-packet abandons the packet; no flush is performed.
- States: IDLE, LOCKED.
- IDLE:
  - Grant=0, Xbar_sel=00000.
  - If Req!=0, search from rr_ptr upward, mod 5; the first set bit is winner w.
  - Next cycle: state=LOCKED, owner=w, Xbar_sel=onehot(w), Busy=1.
  - Allocation latency is 1 cycle. Req in IDLE is never granted in the same cycle.
- LOCKED:
  - Grant[owner] = Req[owner] AND (Credit_cnt != 0); all other Grant bits are 0.
  - The credit test uses the registered count only; a Credit_in in the same cycle does not enable a grant.
  - Grant with Tail[owner]=1: next state=IDLE, rr_ptr=(owner+1) mod 5, Xbar_sel=00000.
  - Req[owner] low: hold LOCKED with Grant=0. The packet lock is kept; other requesters are ignored.
  - Tail without Grant is ignored.
- Throughput and round-robin:
  - Up to 1 flit/cycle in LOCKED.
  - One idle bubble cycle between consecutive packets.
  - rr_ptr changes only on tail completion. Initial order after reset is L, N, E, W, S.
- Credit counter:
  - Send (Valid_out) only: -1.
  - Credit_in only: +1.
  - Both in the same cycle: unchanged.
  - Credit_in at Credit_cnt=CREDITS with no send: count holds at CREDITS, Err set; Err clears only on rst.
  - Underflow cannot occur, because a grant requires a nonzero count.
- Tail and Req outside the current owner: no effect while LOCKED.

Test Plan:
- Reset, CREDITS=4; Req=10000, 3-flit packet, tail on the 3rd flit:
  - Cycle 1: Xbar_sel=10000, Busy=1.
  - Grant=10000 for 3 cycles; Credit_cnt goes 4,3,2,1.
  - Then Busy=0, Xbar_sel=00000.
- Req=11111 held, every flit a tail, Credit_in pulsed each send:
  - Grant sequence 10000, 00001, 00010, 00100, 01000, 10000.
  - Each grant separated by one idle cycle.
- 6-flit packet from N, no Credit_in:
  - 4 Grant=00001 cycles, then Grant=0 with Credit_cnt=0 and Busy=1.
  - Credit_in pulse: one further grant on the next cycle.
- Credit_cnt=2, send and Credit_in in the same cycle -> Credit_cnt stays 2.
- Idle, Credit_cnt=4, Credit_in pulse -> Credit_cnt=4, Err=1 and stays 1 until rst.
- rst asserted mid-packet from E:
  - Next cycle: Grant=0, Xbar_sel=00000, Credit_cnt=4, Err=0.
  - With Req=10010, next allocation picks L (10000).

Source files
------------

// File: rtl/credit_packet_allocator_if.sv
// Purpose : request/grant/credit bundle between the input ports and one
//           router output-port allocator.
// Signals : Req/Tail/Credit_in  - from input ports and downstream credit return
//           Grant/Valid_out     - per-input flit grant and downstream write strobe
//           Xbar_sel            - registered one-hot crossbar owner select
//           Credit_cnt/Busy/Err - credit count, packet-lock and overflow status
interface credit_packet_allocator_if #(
   parameter int unsigned CW = 4
);
   logic [4:0]    Req;
   logic [4:0]    Tail;
   logic          Credit_in;
   logic [4:0]    Grant;
   logic [4:0]    Xbar_sel;
   logic          Valid_out;
   logic [CW-1:0] Credit_cnt;
   logic          Busy;
   logic          Err;

   // Requester / credit-source side
   modport master (
      output Req, Tail, Credit_in,
      input  Grant, Xbar_sel, Valid_out, Credit_cnt, Busy, Err
   );

   // Allocator side
   modport slave (
      input  Req, Tail, Credit_in,
      output Grant, Xbar_sel, Valid_out, Credit_cnt, Busy, Err
   );
endinterface

// File: rtl/credit_packet_allocator.sv
// Purpose : output-port allocator for a 5-port mesh router. Locks the output
//           to one input (N,E,W,S,L) for a whole packet, round-robin between
//           packets, and gates each flit on downstream credits.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset
//           bus  - credit_packet_allocator_if.slave (Req, Tail, Credit_in in;
//                  Grant, Xbar_sel, Valid_out, Credit_cnt, Busy, Err out)
module credit_packet_allocator #(
   parameter int unsigned CREDITS = 4,
   parameter int unsigned CW      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   credit_packet_allocator_if.slave   bus
);

   localparam int unsigned NPORTS = 5;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [2:0]    r_owner;
   logic [2:0]    r_rr_ptr;
   logic [4:0]    r_xbar_sel;
   logic [CW-1:0] r_credit;
   logic          r_err;

   logic [2:0]    w_winner;
   logic          w_found;
   logic [4:0]    w_grant;
   logic          w_send;
   logic          w_tail_done;

   // Round-robin search starting at r_rr_ptr, wrapping mod 5
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      for (int k = 0; k < int'(NPORTS); k++) begin
         int idx;
         idx = (int'(r_rr_ptr) + k) % int'(NPORTS);
         if (!w_found && bus.Req[3'(idx)]) begin
            w_found  = 1'b1;
            w_winner = 3'(idx);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (|bus.Req)   w_state_nxt = LOCKED;
         LOCKED:  if (w_tail_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM output: grant only the owner, only on the registered credit count
   always_comb begin
      w_grant = '0;
      if (!rst && (r_state == LOCKED) && bus.Req[r_owner] && (r_credit != '0))
         w_grant[r_owner] = 1'b1;
   end

   assign w_send      = |w_grant;
   assign w_tail_done = w_send && bus.Tail[r_owner];

   // Owner capture, crossbar select and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner    <= '0;
         r_rr_ptr   <= 3'd4;
         r_xbar_sel <= '0;
      end else begin
         if ((r_state == IDLE) && w_found) begin
            r_owner    <= w_winner;
            r_xbar_sel <= 5'b00001 << w_winner;
         end
         if (w_tail_done) begin
            r_rr_ptr   <= (r_owner == 3'd4) ? 3'd0 : r_owner + 3'd1;
            r_xbar_sel <= '0;
         end
      end
   end

   // Credit counter; a return at full count is an overflow and is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         r_credit <= CW'(CREDITS);
         r_err    <= 1'b0;
      end else begin
         case ({w_send, bus.Credit_in})
            2'b10:   r_credit <= r_credit - CW'(1);
            2'b01: begin
               if (r_credit == CW'(CREDITS)) r_err    <= 1'b1;
               else                          r_credit <= r_credit + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.Grant      = w_grant;
   assign bus.Valid_out  = w_send;
   assign bus.Xbar_sel   = r_xbar_sel;
   assign bus.Credit_cnt = r_credit;
   assign bus.Busy       = (r_state == LOCKED);
   assign bus.Err        = r_err;

endmodule
